// File: rtl/nn_pkg.sv
// Shared widths, FIFO state encoding and the per-lane requantizer.
// Optional build macro: LEAKY_RELU_EN selects leaky ReLU with signed output.
package nn_pkg;

    localparam int HID_IN_W        = 5;
    localparam int HID_ACC_W       = 12;
    localparam int OUT_IN_W        = 12;
    localparam int OUT_ACC_W       = 17;
    localparam int WEIGHT_W        = 5;
    localparam int DEF_NUM_NEURONS = 4;

    // Lanes are carried sign-extended to a common width so one function
    // serves every layer width; callers keep the low OUT_W bits.
    typedef logic signed [31:0] lane_t;

    typedef enum logic [1:0] {
        FIFO_EMPTY = 2'd0,
        FIFO_ONE   = 2'd1,
        FIFO_TWO   = 2'd2
    } fifo_state_e;

`ifdef LEAKY_RELU_EN
    localparam bit LEAKY = 1'b1;
`else
    localparam bit LEAKY = 1'b0;
`endif

    function automatic lane_t requant(lane_t x, int shift, int out_w);
        lane_t v;
        lane_t r;
        lane_t hi;
        lane_t lo;
        if (x < 0) begin
            v = LEAKY ? (x >>> 3) : '0;
        end else begin
            v = x;
        end
        if (shift == 0) begin
            r = v;
        end else begin
            r = (v + (lane_t'(1) <<< (shift - 1))) >>> shift;
        end
        hi = (lane_t'(1) <<< (out_w - 1)) - lane_t'(1);
        lo = LEAKY ? -(lane_t'(1) <<< (out_w - 1)) : '0;
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/relu_requant_stage_if.sv
// Neuron-result input and requantized valid/ready output of the stage.
// slave is the stage side; master is the neuron layer plus next layer.
interface relu_requant_stage_if
    import nn_pkg::*;
#(
    parameter int NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int IN_W        = HID_ACC_W,
    parameter int OUT_W       = HID_IN_W
);

    logic                         in_valid;
    logic [NUM_NEURONS*IN_W-1:0]  in_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [NUM_NEURONS*OUT_W-1:0] out_data;
    logic [1:0]                   fill_level;
    logic                         overflow;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  fill_level,
        input  overflow
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data,
        output fill_level,
        output overflow
    );

endinterface

// File: rtl/fifo2_buf.sv
// Two-entry synchronous FIFO; a push into a full FIFO without a pop is
// dropped and reported on drop, leaving the stored entries untouched.
module fifo2_buf
    import nn_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic [1:0]   level,
    output logic         drop
);

    fifo_state_e  state_q;
    fifo_state_e  state_d;
    logic [W-1:0] head_q;
    logic [W-1:0] head_d;
    logic [W-1:0] tail_q;
    logic [W-1:0] tail_d;

    // Occupancy and storage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FIFO_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Next occupancy, entry movement and drop detection.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        drop    = 1'b0;
        unique case (state_q)
            FIFO_EMPTY: begin
                if (push) begin
                    head_d  = din;
                    state_d = FIFO_ONE;
                end
            end
            FIFO_ONE: begin
                if (push && pop) begin
                    head_d = din;
                end else if (push) begin
                    tail_d  = din;
                    state_d = FIFO_TWO;
                end else if (pop) begin
                    state_d = FIFO_EMPTY;
                end
            end
            FIFO_TWO: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = FIFO_ONE;
                    if (push) begin
                        tail_d  = din;
                        state_d = FIFO_TWO;
                    end
                end else if (push) begin
                    drop = 1'b1;
                end
            end
            default: begin
                state_d = FIFO_EMPTY;
            end
        endcase
    end

    assign dout  = head_q;
    assign valid = (state_q != FIFO_EMPTY);
    assign level = state_q;

endmodule

// File: rtl/relu_requant_stage.sv
// ReLU + round-half-up requantization of a neuron layer, buffered 2 deep.
// Optional build macro: LEAKY_RELU_EN (leaky ReLU, signed saturation).
module relu_requant_stage
    import nn_pkg::*;
#(
    parameter int NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int IN_W        = HID_ACC_W,
    parameter int OUT_W       = HID_IN_W,
    parameter int SHIFT       = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    relu_requant_stage_if.slave  bus
);

    logic [NUM_NEURONS*OUT_W-1:0] vec;
    logic                         drop;
    logic                         overflow_q;

    for (genvar k = 0; k < NUM_NEURONS; k++) begin : g_lane
        lane_t x;
        lane_t r;
        logic  unused_hi;
        assign x = lane_t'($signed(bus.in_data[k*IN_W +: IN_W]));
        assign r = requant(x, SHIFT, OUT_W);
        assign vec[k*OUT_W +: OUT_W] = r[OUT_W-1:0];
        assign unused_hi = ^r[31:OUT_W];
    end

    fifo2_buf #(
        .W (NUM_NEURONS*OUT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.in_valid),
        .pop   (bus.out_ready),
        .din   (vec),
        .dout  (bus.out_data),
        .valid (bus.out_valid),
        .level (bus.fill_level),
        .drop  (drop)
    );

    // Sticky drop flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_relu_requant_stage.sv
// Bench for relu_requant_stage: directed table, corner sequences and
// random traffic against an arithmetic queue model.
module tb_relu_requant_stage;

    localparam int NN    = 4;
    localparam int IN_W  = 12;
    localparam int OUT_W = 5;
    localparam int SH    = 6;
`ifdef LEAKY_RELU_EN
    localparam bit LK = 1'b1;
`else
    localparam bit LK = 1'b0;
`endif

    typedef logic [NN*IN_W-1:0]  ivec_t;
    typedef logic [NN*OUT_W-1:0] ovec_t;
    typedef struct {
        ivec_t din;
        ovec_t dout;
    } vec_rec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    relu_requant_stage_if #(.NUM_NEURONS(NN), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    relu_requant_stage #(
        .NUM_NEURONS (NN),
        .IN_W        (IN_W),
        .OUT_W       (OUT_W),
        .SHIFT       (SH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int    n_pass = 0;
    int    n_total = 0;
    ovec_t q[$];
    bit    ovf_m = 1'b0;

    function automatic int fdiv(int a, int b);
        int d;
        d = a / b;
        if ((a % b != 0) && (a < 0)) d = d - 1;
        return d;
    endfunction

    function automatic int ref_lane(int x);
        int v;
        int r;
        int hi;
        int lo;
        if (x < 0) v = LK ? fdiv(x, 8) : 0;
        else v = x;
        r  = (SH == 0) ? v : fdiv(v + 2 ** (SH - 1), 2 ** SH);
        hi = 2 ** (OUT_W - 1) - 1;
        lo = LK ? -(2 ** (OUT_W - 1)) : 0;
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return r;
    endfunction

    function automatic ovec_t ref_vec(ivec_t d);
        ovec_t o;
        int x;
        for (int k = 0; k < NN; k++) begin
            x = $signed(d[k*IN_W +: IN_W]);
            o[k*OUT_W +: OUT_W] = OUT_W'(ref_lane(x));
        end
        return o;
    endfunction

    function automatic ivec_t pk_in(int a, int b, int c, int d);
        int t[4];
        ivec_t v;
        t = '{a, b, c, d};
        for (int k = 0; k < NN; k++) v[k*IN_W +: IN_W] = IN_W'(t[k]);
        return v;
    endfunction

    function automatic ovec_t pk_out(int a, int b, int c, int d);
        int t[4];
        ovec_t v;
        t = '{a, b, c, d};
        for (int k = 0; k < NN; k++) v[k*OUT_W +: OUT_W] = OUT_W'(t[k]);
        return v;
    endfunction

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, got, exp);
    endtask

    task automatic step(bit r, bit iv, ivec_t d, bit rdy);
        bit pop;
        rst           = r;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = rdy;
        @(posedge clk);
        if (r) begin
            q.delete();
            ovf_m = 1'b0;
        end else begin
            pop = rdy && (q.size() != 0);
            if (iv && !pop && q.size() == 2) begin
                ovf_m = 1'b1;
            end else begin
                if (pop) void'(q.pop_front());
                if (iv) q.push_back(ref_vec(d));
            end
        end
        @(negedge clk);
        check("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
        check("fill_level", 64'(bus.fill_level), 64'(q.size()));
        check("overflow", 64'(bus.overflow), 64'(ovf_m));
        if (q.size() != 0) check("out_data", 64'(bus.out_data), 64'(q[0]));
    endtask

    vec_rec_t tbl[$];
    ivec_t    va;
    ivec_t    vb;
    ivec_t    vc;
    logic [63:0] rnd;

    initial begin
        tbl.push_back('{pk_in(100, 96, 95, -50), pk_out(2, 2, 1, 0)});
        tbl.push_back('{pk_in(2047, 991, 992, 0), pk_out(15, 15, 15, 0)});
        tbl.push_back('{pk_in(160, 223, 224, 1), pk_out(3, 3, 4, 0)});
`ifdef LEAKY_RELU_EN
        tbl.push_back('{pk_in(-512, -16, 100, -2048), pk_out(-1, 0, 2, -4)});
`else
        tbl.push_back('{pk_in(0, 31, 32, -2048), pk_out(0, 0, 1, 0)});
        tbl.push_back('{pk_in(-1, 63, 1023, 1024), pk_out(0, 1, 15, 15)});
`endif

        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, pk_in(5, 5, 5, 5), 1'b0);
        check("rst_data", 64'(bus.out_data), 64'(0));

        foreach (tbl[i]) begin
            step(1'b0, 1'b1, tbl[i].din, 1'b1);
            check("tbl_data", 64'(bus.out_data), 64'(tbl[i].dout));
            step(1'b0, 1'b0, '0, 1'b1);
            check("tbl_idle", 64'(bus.out_valid), 64'(0));
        end

        va = pk_in(100, 96, 95, -50);
        vb = pk_in(2047, 991, 992, 0);
        vc = pk_in(160, 223, 224, 1);
        step(1'b0, 1'b1, va, 1'b0);
        step(1'b0, 1'b1, vb, 1'b0);
        step(1'b0, 1'b1, vc, 1'b0);
        check("bp_level", 64'(bus.fill_level), 64'(2));
        check("bp_ovf", 64'(bus.overflow), 64'(1));
        check("bp_head_a", 64'(bus.out_data), 64'(pk_out(2, 2, 1, 0)));
        step(1'b0, 1'b0, '0, 1'b1);
        check("bp_head_b", 64'(bus.out_data), 64'(pk_out(15, 15, 15, 0)));
        step(1'b0, 1'b0, '0, 1'b1);
        check("bp_empty", 64'(bus.out_valid), 64'(0));
        check("bp_sticky", 64'(bus.overflow), 64'(1));

        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, pk_in(64, 0, 0, 0), 1'b0);
        step(1'b0, 1'b1, pk_in(128, 0, 0, 0), 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, pk_in(192 + 64 * i, i * 64, 0, 0), 1'b1);
            check("pp_level", 64'(bus.fill_level), 64'(2));
        end
        check("pp_ovf", 64'(bus.overflow), 64'(0));
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, '0, 1'b1);

        step(1'b0, 1'b1, va, 1'b0);
        step(1'b0, 1'b1, vb, 1'b0);
        step(1'b0, 1'b1, vc, 1'b0);
        step(1'b1, 1'b1, vc, 1'b1);
        check("mr_level", 64'(bus.fill_level), 64'(0));
        check("mr_valid", 64'(bus.out_valid), 64'(0));
        check("mr_ovf", 64'(bus.overflow), 64'(0));
        step(1'b0, 1'b0, '0, 1'b1);
        check("mr_none", 64'(bus.out_valid), 64'(0));

        for (int i = 0; i < 400; i++) begin
            rnd = {$urandom, $urandom};
            step(1'b0, ($urandom_range(0, 3) != 0), rnd[47:0],
                 ($urandom_range(0, 2) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
